// File: rtl/clksel_pkg.sv
// Shared definitions for the clock-source selection controller: FSM encoding
// and a width helper for the cycle counters.
package clksel_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        GATE   = 2'd1,
        SWAP   = 2'd2,
        UNGATE = 2'd3
    } clksel_state_e;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_GATE   = 2'd1;
    localparam logic [1:0] ST_SWAP   = 2'd2;
    localparam logic [1:0] ST_UNGATE = 2'd3;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clksel_ctrl_if.sv
// Level-signal bundle between the DIP/health sources and the clock-control
// mux. No handshake: inputs are asynchronous levels, outputs are registered.
interface clksel_ctrl_if #(
    parameter int NSRC = 4,
    parameter int SELW = $clog2(NSRC)
);
    logic [SELW-1:0] req_sel;
    logic [NSRC-1:0] src_ok;
    logic [SELW-1:0] clkselect;
    logic            clkena;
    logic [SELW-1:0] cur_sel;
    logic            switching;
    logic            fallback;
    logic [7:0]      sw_count;
    logic [1:0]      dbg_state;

    modport master (
        output req_sel, src_ok,
        input  clkselect, clkena, cur_sel, switching, fallback, sw_count, dbg_state
    );

    modport slave (
        input  req_sel, src_ok,
        output clkselect, clkena, cur_sel, switching, fallback, sw_count, dbg_state
    );
endinterface

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a stability counter; the accepted value
// only moves once the synchronised input has held for DEBOUNCE cycles.
module sync_debounce
    import clksel_pkg::*;
#(
    parameter int          W        = 2,
    parameter int          DEBOUNCE = 1024,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] acc_o
);
    localparam int            CW     = cnt_width(DEBOUNCE + 1);
    localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE);

    logic [W-1:0]  meta_q;
    logic [W-1:0]  sync_q;
    logic [W-1:0]  last_q;
    logic [W-1:0]  acc_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] held_d;

    // held_d = cycles the synchronised value has been constant, including this one
    always_comb begin
        held_d = cnt_q;
        if (sync_q != last_q) begin
            held_d = CW'(1);
        end else if (cnt_q != TARGET) begin
            held_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            last_q <= RST_VAL;
            acc_q  <= RST_VAL;
            cnt_q  <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            last_q <= sync_q;
            cnt_q  <= held_d;
            if (held_d == TARGET) begin
                acc_q <= sync_q;
            end
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/clksel_ctrl.sv
// Clock-source selection controller: resolves a healthy target from the
// debounced request and sequences every mux change as gate -> swap -> ungate.
module clksel_ctrl
    import clksel_pkg::*;
#(
    parameter int NSRC        = 4,
    parameter int SELW        = $clog2(NSRC),
    parameter int DEFAULT_SRC = 2,
    parameter int DEBOUNCE    = 1024,
    parameter int SETTLE      = 16
) (
    input  logic        clk,
    input  logic        rst,
    clksel_ctrl_if.slave bus
);
    localparam logic [SELW-1:0] DEF_SEL     = SELW'(DEFAULT_SRC);
    localparam int              SCW         = cnt_width(SETTLE);
    localparam logic [SCW-1:0]  SETTLE_LAST = SCW'(SETTLE - 1);

    logic [SELW-1:0] req_acc;
    logic [NSRC-1:0] ok_meta_q;
    logic [NSRC-1:0] ok_q;

    logic            req_ok;
    logic            def_ok;
    logic [SELW-1:0] tgt;

    logic [1:0]      state_q, state_d;
    logic [SCW-1:0]  cnt_q, cnt_d;
    logic [SELW-1:0] nxt_q, nxt_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic            ena_q, ena_d;
    logic [7:0]      sw_q, sw_d;
    logic            boot_q, boot_d;

    sync_debounce #(
        .W        (SELW),
        .DEBOUNCE (DEBOUNCE),
        .RST_VAL  (DEF_SEL)
    ) u_req_sync (
        .clk   (clk),
        .rst   (rst),
        .d_i   (bus.req_sel),
        .acc_o (req_acc)
    );

    // Health resets to all-healthy so the post-reset target is the default source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok_meta_q <= '1;
            ok_q      <= '1;
        end else begin
            ok_meta_q <= bus.src_ok;
            ok_q      <= ok_meta_q;
        end
    end

    always_comb begin
        req_ok = 1'b0;
        if (int'(req_acc) < NSRC) begin
            req_ok = ok_q[req_acc];
        end
        def_ok = ok_q[DEFAULT_SRC];
        tgt    = sel_q;
        if (req_ok) begin
            tgt = req_acc;
        end else if (def_ok) begin
            tgt = DEF_SEL;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nxt_d   = nxt_q;
        sel_d   = sel_q;
        ena_d   = ena_q;
        sw_d    = sw_q;
        boot_d  = boot_q;
        case (state_q)
            ST_RUN: begin
                ena_d = 1'b1;
                if (tgt != sel_q) begin
                    nxt_d   = tgt;
                    state_d = ST_GATE;
                    ena_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_GATE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SWAP;
                    sel_d   = nxt_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SCW'(1);
                end
            end
            ST_SWAP: begin
                state_d = ST_UNGATE;
                cnt_d   = '0;
            end
            ST_UNGATE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                    ena_d   = 1'b1;
                    cnt_d   = '0;
                    boot_d  = 1'b0;
                    // The ungate that follows reset is not a completed switch.
                    if (!boot_q && sw_q != 8'hFF) begin
                        sw_d = sw_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + SCW'(1);
                end
            end
            default: begin
                state_d = ST_UNGATE;
                ena_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_UNGATE;
            cnt_q   <= '0;
            nxt_q   <= DEF_SEL;
            sel_q   <= DEF_SEL;
            ena_q   <= 1'b0;
            sw_q    <= 8'd0;
            boot_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nxt_q   <= nxt_d;
            sel_q   <= sel_d;
            ena_q   <= ena_d;
            sw_q    <= sw_d;
            boot_q  <= boot_d;
        end
    end

    assign bus.clkselect = sel_q;
    assign bus.cur_sel   = sel_q;
    assign bus.clkena    = ena_q;
    assign bus.switching = (state_q != ST_RUN);
    assign bus.fallback  = ~req_ok;
    assign bus.sw_count  = sw_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_clksel_ctrl.sv
// Directed bench for clksel_ctrl with short DEBOUNCE/SETTLE so every phase
// boundary can be checked cycle-exactly.
module tb_clksel_ctrl;
    import clksel_pkg::*;

    localparam int NSRC = 4;
    localparam int SELW = 2;
    localparam int DEF  = 2;
    localparam int DEB  = 8;
    localparam int SET  = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [SELW-1:0] exp_q[$];
    logic [SELW-1:0] mon_prev = 2'd2;
    logic [SELW-1:0] mon_exp;

    clksel_ctrl_if #(.NSRC(NSRC), .SELW(SELW)) bus ();

    clksel_ctrl #(
        .NSRC        (NSRC),
        .SELW        (SELW),
        .DEFAULT_SRC (DEF),
        .DEBOUNCE    (DEB),
        .SETTLE      (SET)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every select change outside reset must match the next queued expectation.
    always begin
        @(posedge clk);
        #2;
        if (rst) begin
            mon_prev = bus.clkselect;
        end else if (bus.clkselect !== mon_prev) begin
            mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : ~bus.clkselect;
            checks++;
            assert (bus.clkselect === mon_exp) else begin
                errors++;
                $error("FAIL sel_change: observed=%0h expected=%0h", bus.clkselect, mon_exp);
            end
            mon_prev = bus.clkselect;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        rst = 1'b1;
        bus.req_sel = 2'd2;
        bus.src_ok  = 4'hF;
        tick(3);
        chk("rst_sel",       bus.clkselect, 2);
        chk("rst_cur",       bus.cur_sel, 2);
        chk("rst_ena",       bus.clkena, 0);
        chk("rst_cnt",       bus.sw_count, 0);
        chk("rst_switching", bus.switching, 1);
        chk("rst_fallback",  bus.fallback, 0);
        chk("rst_state",     bus.dbg_state, ST_UNGATE);
        rst = 1'b0;
        tick(SET - 1);
        chk("boot_gated", bus.clkena, 0);
        tick(1);
        chk("boot_ena",   bus.clkena, 1);
        chk("boot_cnt",   bus.sw_count, 0);
        chk("boot_run",   bus.switching, 0);
        chk("boot_state", bus.dbg_state, ST_RUN);

        // Normal switch 2 -> 0
        bus.req_sel = 2'd0;
        exp_q.push_back(2'd0);
        tick(DEB + 2);
        chk("norm_pre_ena", bus.clkena, 1);
        tick(1);
        chk("norm_gate_ena", bus.clkena, 0);
        chk("norm_gate_sw",  bus.switching, 1);
        tick(SET - 1);
        chk("norm_sel_old", bus.clkselect, 2);
        tick(1);
        chk("norm_sel_new", bus.clkselect, 0);
        chk("norm_cur_new", bus.cur_sel, 0);
        tick(SET);
        chk("norm_ungate", bus.clkena, 0);
        tick(1);
        chk("norm_ena", bus.clkena, 1);
        chk("norm_cnt", bus.sw_count, 1);

        // Bounce 0 <-> 1 every DEB/2 cycles: no switch
        for (int i = 0; i < 6; i++) begin
            bus.req_sel = (i % 2 == 0) ? 2'd1 : 2'd0;
            tick(DEB / 2);
            chk("bounce_ena", bus.clkena, 1);
        end
        chk("bounce_sel", bus.clkselect, 0);
        bus.req_sel = 2'd1;
        exp_q.push_back(2'd1);
        tick(DEB + 2);
        chk("hold_pre_ena", bus.clkena, 1);
        tick(1);
        chk("hold_gate", bus.clkena, 0);
        tick(2 * SET + 1);
        chk("hold_ena", bus.clkena, 1);
        chk("hold_sel", bus.clkselect, 1);
        chk("hold_cnt", bus.sw_count, 2);
        tick(20);
        chk("hold_once_sw",  bus.switching, 0);
        chk("hold_once_cnt", bus.sw_count, 2);

        // Fallback: request 3 while source 3 unhealthy -> default 2
        bus.src_ok  = 4'b0111;
        bus.req_sel = 2'd3;
        exp_q.push_back(2'd2);
        tick(DEB + 1);
        chk("fb_pre", bus.fallback, 0);
        tick(1);
        chk("fb_set",     bus.fallback, 1);
        chk("fb_set_ena", bus.clkena, 1);
        tick(1);
        chk("fb_gate", bus.clkena, 0);
        tick(2 * SET + 1);
        chk("fb_ena", bus.clkena, 1);
        chk("fb_sel", bus.clkselect, 2);
        chk("fb_flag", bus.fallback, 1);
        chk("fb_cnt", bus.sw_count, 3);
        tick(10);
        chk("fb_hold_sel", bus.clkselect, 2);
        chk("fb_hold_sw",  bus.switching, 0);
        bus.src_ok = 4'hF;
        exp_q.push_back(2'd3);
        tick(1);
        chk("fb_heal_sync", bus.fallback, 1);
        tick(1);
        chk("fb_heal_flag", bus.fallback, 0);
        chk("fb_heal_ena",  bus.clkena, 1);
        tick(1);
        chk("fb_heal_gate", bus.clkena, 0);
        tick(2 * SET + 1);
        chk("fb_heal_ena2", bus.clkena, 1);
        chk("fb_heal_sel",  bus.clkselect, 3);
        chk("fb_heal_cnt",  bus.sw_count, 4);

        // Lock loss on source 0
        bus.req_sel = 2'd0;
        exp_q.push_back(2'd0);
        tick(DEB + 3);
        chk("ll_prep_gate", bus.clkena, 0);
        tick(2 * SET + 1);
        chk("ll_prep_sel", bus.clkselect, 0);
        chk("ll_prep_cnt", bus.sw_count, 5);
        bus.src_ok = 4'b1110;
        exp_q.push_back(2'd2);
        tick(2);
        chk("ll_pre_ena", bus.clkena, 1);
        tick(1);
        chk("ll_gate",     bus.clkena, 0);
        chk("ll_fallback", bus.fallback, 1);
        tick(2 * SET + 1);
        chk("ll_ena", bus.clkena, 1);
        chk("ll_sel", bus.clkselect, 2);
        chk("ll_cnt", bus.sw_count, 6);
        bus.src_ok = 4'b0000;
        tick(20);
        chk("none_sel", bus.clkselect, 2);
        chk("none_sw",  bus.switching, 0);
        chk("none_ena", bus.clkena, 1);
        chk("none_cnt", bus.sw_count, 6);

        // Mid-switch request change: two back-to-back switches
        bus.src_ok = 4'hF;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        tick(2);
        chk("mid_pre_ena", bus.clkena, 1);
        tick(1);
        chk("mid_gate", bus.clkena, 0);
        bus.req_sel = 2'd1;
        tick(SET - 1);
        chk("mid_sel_old", bus.clkselect, 2);
        tick(1);
        chk("mid_sel_nxt", bus.clkselect, 0);
        tick(SET);
        chk("mid_ungate", bus.clkena, 0);
        tick(1);
        chk("mid_run_ena", bus.clkena, 1);
        chk("mid_cnt1",    bus.sw_count, 7);
        tick(1);
        chk("mid_regate",  bus.clkena, 0);
        chk("mid_regate_sw", bus.switching, 1);
        tick(2 * SET + 1);
        chk("mid_ena2", bus.clkena, 1);
        chk("mid_sel2", bus.clkselect, 1);
        chk("mid_cnt2", bus.sw_count, 8);

        // Reset asserted during SWAP
        bus.req_sel = 2'd0;
        exp_q.push_back(2'd0);
        tick(DEB + 2);
        chk("rs_pre_ena", bus.clkena, 1);
        tick(1);
        chk("rs_gate", bus.clkena, 0);
        tick(SET);
        chk("rs_swap_state", bus.dbg_state, ST_SWAP);
        chk("rs_swap_sel",   bus.clkselect, 0);
        rst = 1'b1;
        #1;
        chk("rs_ena",   bus.clkena, 0);
        chk("rs_sel",   bus.clkselect, 2);
        chk("rs_cur",   bus.cur_sel, 2);
        chk("rs_sw",    bus.switching, 1);
        chk("rs_cnt",   bus.sw_count, 0);
        chk("rs_state", bus.dbg_state, ST_UNGATE);
        chk("rs_fb",    bus.fallback, 0);
        bus.req_sel = 2'd2;
        tick(2);
        rst = 1'b0;
        tick(SET - 1);
        chk("rs_boot_gated", bus.clkena, 0);
        tick(1);
        chk("rs_boot_ena", bus.clkena, 1);
        chk("rs_boot_cnt", bus.sw_count, 0);
        chk("rs_boot_sel", bus.clkselect, 2);

        tick(5);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
